wb_master_arbiter: RTL and testbench

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_master_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// wb_master_arbiter
//
// Two-master Wishbone arbiter. It shares one slave-side bus between the LIMB
// bridge (m0) and a secondary master (m1). Ties are broken in favour of the
// master that was not served last. A grant is held for as long as the owner
// keeps cyc high, so bursts are never preempted. A watchdog ends strobes that
// the slave never acknowledges with a one-cycle bus error.
//
// Parameters
//   TIMEOUT   number of consecutive unacknowledged strobe cycles before the
//             bus error is raised (2..255)
//
// Ports
//   clk, nreset              system clock; asynchronous active-low reset
//   m0_*_i / m1_*_i          master request side (adr 36, dat 32, sel 4,
//                            we, stb, cyc)
//   m0_*_o / m1_*_o          read data, ack and err back to each master
//   s_*_o                    shared slave-side request bus
//   s_dat_i, s_ack_i         slave read data and acknowledge
//   gnt_o                    one-hot grant (01 = m0, 10 = m1, 00 = idle)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module wb_master_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nreset,

  input  logic [35:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [35:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [35:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  gnt_o
);

  // The state encoding is the one-hot grant itself, so gnt_o is registered.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  // Watchdog count at which the current strobe cycle is the TIMEOUT-th one.
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic        last_m1;
  logic [7:0]  wd_cnt;
  logic        wd_hit;
  logic [1:0]  rst_sync;
  logic        arb_en;

  // Reset release synchroniser. Assertion is asynchronous. Release reaches the
  // arbiter only after two rising edges, so a request present while nreset
  // deasserts cannot be granted before the second edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign arb_en = rst_sync[1];

  // Grant register and fairness memory. last_m1 resets to 1 so that m0 wins
  // the first tie. It is updated only when a grant is issued from IDLE.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next != IDLE) begin
        last_m1 <= (state_next == GNT1);
      end
    end
  end

  // Arbitration. Once granted, a master keeps the bus until it drops cyc. The
  // return to IDLE guarantees at least one idle cycle between two grants.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (arb_en) begin
          if (m0_cyc_i && m1_cyc_i) begin
            state_next = last_m1 ? GNT0 : GNT1;
          end else if (m0_cyc_i) begin
            state_next = GNT0;
          end else if (m1_cyc_i) begin
            state_next = GNT1;
          end
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_next = IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Slave-side multiplexer. It passes the granted master straight through and
  // holds the bus at zero when idle.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    case (state)
      GNT0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_stb_o = m0_stb_i;
        s_cyc_o = m0_cyc_i;
      end
      GNT1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_stb_o = m1_stb_i;
        s_cyc_o = m1_cyc_i;
      end
      default: begin
      end
    endcase
  end

  // The error fires on the strobe cycle that would bring the count to TIMEOUT.
  // An ack in that same cycle takes priority. A cycle in which the owner has
  // already dropped cyc is an abort and never produces an error.
  assign wd_hit = s_cyc_o && s_stb_o && !s_ack_i && (wd_cnt == WD_LIMIT);

  // Watchdog counter. It clears on ack, on an idle strobe, on any grant
  // change and after it fires. Otherwise it counts and saturates at its
  // maximum value instead of wrapping.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wd_cnt <= 8'd0;
    end else if ((state_next != state) || !s_stb_o || s_ack_i || wd_hit) begin
      wd_cnt <= 8'd0;
    end else if (wd_cnt != 8'hFF) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  assign gnt_o    = state;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i && m0_stb_i && (state == GNT0);
  assign m1_ack_o = s_ack_i && m1_stb_i && (state == GNT1);
  assign m0_err_o = wd_hit && (state == GNT0);
  assign m1_err_o = wd_hit && (state == GNT1);

endmodule

// File: tb/tb_wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_master_arbiter
//
// Self-checking bench for wb_master_arbiter with TIMEOUT = 4. A directed
// sequence covers the arbitration, timeout, burst and reset scenarios. A
// randomized phase follows it. Every cycle the bench compares all DUT outputs
// against a small behavioural model: who owns the bus, who was served last,
// and how many unanswered strobe cycles the owner has seen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wb_master_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        nreset;
  logic [35:0] m0_adr_i, m1_adr_i;
  logic [31:0] m0_dat_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m1_we_i, m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [35:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  int checks = 0;
  int fails  = 0;

  // Model state: owner is -1 when the bus is idle, otherwise 0 or 1.
  int owner      = -1;
  int lastServed = 1;
  int waited     = 0;

  wb_master_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .nreset(nreset),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish before 200us");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int master, input logic cyc, input logic stb,
                               input logic we, input logic [35:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel);
    if (master == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
      m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
      m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  // Compare every output against what the model expects for this cycle.
  task automatic checkOutput();
    logic [1:0]  eg;
    logic [35:0] eadr;
    logic [31:0] edat;
    logic [3:0]  esel;
    logic        ewe, estb, ecyc, ea0, ea1, ee0, ee1;
    eg = 2'b00; eadr = '0; edat = '0; esel = '0;
    ewe = 0; estb = 0; ecyc = 0; ea0 = 0; ea1 = 0; ee0 = 0; ee1 = 0;
    if (owner == 0) begin
      eg = 2'b01; eadr = m0_adr_i; edat = m0_dat_i; esel = m0_sel_i;
      ewe = m0_we_i; estb = m0_stb_i; ecyc = m0_cyc_i;
      ea0 = s_ack_i && m0_stb_i;
      ee0 = m0_cyc_i && m0_stb_i && !s_ack_i && (waited == TO - 1);
    end else if (owner == 1) begin
      eg = 2'b10; eadr = m1_adr_i; edat = m1_dat_i; esel = m1_sel_i;
      ewe = m1_we_i; estb = m1_stb_i; ecyc = m1_cyc_i;
      ea1 = s_ack_i && m1_stb_i;
      ee1 = m1_cyc_i && m1_stb_i && !s_ack_i && (waited == TO - 1);
    end
    checkValue("gnt", gnt_o, eg);
    checkValue("s_adr", s_adr_o, eadr);
    checkValue("s_dat", s_dat_o, edat);
    checkValue("s_sel", s_sel_o, esel);
    checkValue("s_we", s_we_o, ewe);
    checkValue("s_stb", s_stb_o, estb);
    checkValue("s_cyc", s_cyc_o, ecyc);
    checkValue("m0_ack", m0_ack_o, ea0);
    checkValue("m1_ack", m1_ack_o, ea1);
    checkValue("m0_err", m0_err_o, ee0);
    checkValue("m1_err", m1_err_o, ee1);
    checkValue("m0_dat_o", m0_dat_o, s_dat_i);
    checkValue("m1_dat_o", m1_dat_o, s_dat_i);
  endtask

  // Model update at a rising edge, from the request-level rules.
  task automatic modelAdvance();
    logic cycOwn, stbOwn;
    if (owner < 0) begin
      if (m0_cyc_i && m1_cyc_i) owner = (lastServed == 1) ? 0 : 1;
      else if (m0_cyc_i)        owner = 0;
      else if (m1_cyc_i)        owner = 1;
      if (owner >= 0) lastServed = owner;
      waited = 0;
    end else begin
      cycOwn = (owner == 0) ? m0_cyc_i : m1_cyc_i;
      stbOwn = (owner == 0) ? m0_stb_i : m1_stb_i;
      if (!cycOwn) begin
        owner  = -1;
        waited = 0;
      end else if (stbOwn && !s_ack_i) begin
        waited = (waited == TO - 1) ? 0 : waited + 1;
      end else begin
        waited = 0;
      end
    end
  endtask

  // One bus cycle: check mid-cycle, then advance the model on the edge.
  task automatic tick();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  // Release reset with both masters requesting and wait for the first grant.
  // The bench expects no grant at the first edge and m0 winning the tie.
  task automatic releaseAndArbitrate();
    int n;
    applyStimulus(0, 1, 0, 0, '0, '0, '0);
    applyStimulus(1, 1, 0, 0, '0, '0, '0);
    s_ack_i = 0;
    nreset  = 1;
    @(posedge clk); #1;
    n = 1;
    checkValue("sync_hold", gnt_o, 2'b00);
    while (gnt_o == 2'b00 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    checkValue("tie_after_reset", gnt_o, 2'b01);
    checkValue("arb_latency", (n >= 2), 1'b1);
    owner = 0; lastServed = 0; waited = 0;
  endtask

  initial begin
    logic c;
    nreset = 0;
    s_ack_i = 0;
    s_dat_i = 32'hCAFE_0001;
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0, '0);
    #3;
    checkValue("rst_gnt", gnt_o, 2'b00);
    checkValue("rst_s_cyc", s_cyc_o, 1'b0);
    checkValue("rst_s_adr", s_adr_o, 36'h0);
    checkValue("rst_m0_ack", m0_ack_o, 1'b0);
    checkValue("rst_m0_dat_o", m0_dat_o, 32'hCAFE_0001);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] simultaneous requests after reset");
    releaseAndArbitrate();
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    #1;
    checkValue("m0_hold", gnt_o, 2'b01);
    tick();
    checkValue("idle_gap", gnt_o, 2'b00);
    tick();
    checkValue("m1_after_gap", gnt_o, 2'b10);
    applyStimulus(1, 0, 0, 0, '0, '0, '0);
    tick();

    $display("[TB] m0 write with slave ack on third cycle");
    applyStimulus(0, 1, 1, 1, 36'h0_0000_1234, 32'hDEADBEEF, 4'hF);
    tick();
    checkValue("wr_s_adr", s_adr_o, 36'h0_0000_1234);
    checkValue("wr_s_dat", s_dat_o, 32'hDEADBEEF);
    checkValue("wr_s_we", s_we_o, 1'b1);
    tick();
    tick();
    s_ack_i = 1;
    s_dat_i = 32'h0BAD_F00D;
    #1;
    checkValue("wr_m0_ack", m0_ack_o, 1'b1);
    checkValue("wr_m1_ack", m1_ack_o, 1'b0);
    checkValue("rd_m0_dat_o", m0_dat_o, 32'h0BAD_F00D);
    tick();
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    s_ack_i = 0;
    #1;
    checkValue("wr_ack_single", m0_ack_o, 1'b0);
    tick();

    $display("[TB] timeout with no slave ack");
    applyStimulus(0, 1, 1, 0, 36'h5_0000_0040, 32'h0, 4'hF);
    tick();
    for (int k = 1; k <= 5; k++) begin
      checkValue("to_err_pulse", m0_err_o, (k == TO));
      checkValue("to_gnt_kept", gnt_o, 2'b01);
      tick();
    end
    applyStimulus(0, 0, 1, 0, 36'h5_0000_0040, 32'h0, 4'hF);
    #1;
    checkValue("abort_no_err", m0_err_o, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    tick();

    $display("[TB] ack coincident with timeout");
    applyStimulus(0, 1, 1, 0, 36'h0_0000_0100, 32'h0, 4'h3);
    tick();
    repeat (TO - 1) tick();
    s_ack_i = 1;
    #1;
    checkValue("limit_ack", m0_ack_o, 1'b1);
    checkValue("limit_no_err", m0_err_o, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    s_ack_i = 0;
    tick();

    $display("[TB] m1 burst while m0 waits");
    applyStimulus(1, 1, 1, 1, 36'h2_0000_0000, 32'h1111_2222, 4'hF);
    tick();
    applyStimulus(0, 1, 1, 0, 36'h0_0000_0ABC, 32'h0, 4'hF);
    s_ack_i = 1;
    for (int b = 0; b < 4; b++) begin
      m1_adr_i = 36'h2_0000_0000 + 36'(b * 4);
      #1;
      checkValue("burst_gnt", gnt_o, 2'b10);
      checkValue("burst_m1_ack", m1_ack_o, 1'b1);
      checkValue("burst_m0_ack", m0_ack_o, 1'b0);
      tick();
    end
    applyStimulus(1, 0, 0, 0, '0, '0, '0);
    s_ack_i = 0;
    tick();
    checkValue("burst_release_gap", gnt_o, 2'b00);
    tick();
    checkValue("m0_after_burst", gnt_o, 2'b01);
    s_ack_i = 1;
    tick();
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    s_ack_i = 0;
    tick();

    $display("[TB] reset in the middle of an m1 strobe");
    applyStimulus(1, 1, 1, 0, 36'h3_0000_0010, 32'h5555_AAAA, 4'hF);
    tick();
    checkValue("pre_rst_gnt", gnt_o, 2'b10);
    #2;
    nreset  = 0;
    s_ack_i = 1;
    #1;
    checkValue("mid_rst_s_cyc", s_cyc_o, 1'b0);
    checkValue("mid_rst_gnt", gnt_o, 2'b00);
    checkValue("mid_rst_m1_ack", m1_ack_o, 1'b0);
    checkValue("mid_rst_m1_err", m1_err_o, 1'b0);
    checkValue("mid_rst_dat_o", m1_dat_o, s_dat_i);
    owner = -1; lastServed = 1; waited = 0;
    repeat (2) @(posedge clk);
    #1;
    releaseAndArbitrate();

    $display("[TB] randomized traffic");
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        c = (i == 0) ? m0_cyc_i : m1_cyc_i;
        if ($urandom_range(7) == 0) c = !c;
        applyStimulus(i, c, c && ($urandom_range(3) != 0), 1'($urandom_range(1)),
                      {4'($urandom_range(15)), $urandom()}, $urandom(),
                      4'($urandom_range(15)));
      end
      s_ack_i = ($urandom_range(3) == 0);
      s_dat_i = $urandom();
      tick();
    end
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0, '0);
    s_ack_i = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
